button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 109 ++++++++++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronise, debounce and edge-detect a raw push-button input,
//            with an 8-bit count of accepted presses.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int STABLE_COUNT = 1000000,
  parameter int CTR_WIDTH    = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_in,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam logic                 c_released_level = ACTIVE_LOW;
  localparam logic [CTR_WIDTH-1:0] c_last_count     = CTR_WIDTH'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic                 r_s1;
  logic                 r_s2;
  logic                 w_lvl;
  state_t               r_state;
  logic [CTR_WIDTH-1:0] r_counter;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= c_released_level;
      r_s2 <= c_released_level;
    end else begin
      r_s1 <= button_in;
      r_s2 <= r_s1;
    end
  end

  assign w_lvl = r_s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_counter     <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_lvl) begin
            r_state   <= PRESS_WAIT;
            r_counter <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_lvl) begin
            r_state   <= IDLE;
            r_counter <= '0;
          end else if (r_counter == c_last_count) begin
            r_state     <= PRESSED;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_lvl) begin
            r_state   <= RELEASE_WAIT;
            r_counter <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_lvl) begin
            r_state   <= PRESSED;
            r_counter <= '0;
          end else if (r_counter == c_last_count) begin
            r_state       <= IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_counter <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Scoreboard bench for button_conditioner (STABLE_COUNT=4, active low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_in;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  typedef struct {
    bit         is_press;
    int         cyc;
    logic [7:0] count;
  } ev_t;

  ev_t        exp_q[$];
  int         checks    = 0;
  int         failures  = 0;
  int         cyc       = 0;
  int         n_press   = 0;
  int         n_release = 0;
  logic [7:0] exp_count = 8'd0;

  button_conditioner #(
    .STABLE_COUNT(4),
    .CTR_WIDTH   (20),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_in    (button_in),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every observed pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (press_pulse || release_pulse) begin
      if (press_pulse) n_press++;
      if (release_pulse) n_release++;
      checks++;
      if (press_pulse && release_pulse) begin
        failures++;
        $display("FAIL both_pulses cyc=%0d actual=both high required=at most one", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d press=%0b release=%0b required=none", cyc, press_pulse, release_pulse);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (press_pulse !== e.is_press || cyc != e.cyc || press_count !== e.count || pressed !== e.is_press) begin
          failures++;
          $display("FAIL pulse_event actual: press=%0b cyc=%0d count=%0d pressed=%0b required: press=%0b cyc=%0d count=%0d pressed=%0b",
                   press_pulse, cyc, press_count, pressed, e.is_press, e.cyc, e.count, e.is_press);
        end
      end
    end
  end

  task automatic do_press(input int hold);
    @(negedge clk);
    button_in = 1'b0;
    exp_count = exp_count + 8'd1;
    exp_q.push_back('{1'b1, cyc + 7, exp_count});
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_release(input int hold);
    @(negedge clk);
    button_in = 1'b1;
    exp_q.push_back('{1'b0, cyc + 7, exp_count});
    repeat (hold) @(negedge clk);
  endtask

  task automatic check_level(input string name, input logic exp_p, input logic [7:0] exp_c);
    checks++;
    if (pressed !== exp_p || press_count !== exp_c || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s actual: pressed=%0b count=%0d pending=%0d required: pressed=%0b count=%0d pending=0",
               name, pressed, press_count, exp_q.size(), exp_p, exp_c);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    button_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pressed !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0 || press_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_values actual: p=%0b pp=%0b rp=%0b cnt=%0d required: 0 0 0 0",
               pressed, press_pulse, release_pulse, press_count);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_level("idle_after_reset", 1'b0, 8'd0);
  endtask

  task automatic test_clean_press_release;
    do_press(20);
    check_level("clean_press", 1'b1, 8'd1);
    do_release(20);
    check_level("clean_release", 1'b0, 8'd1);
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); button_in = 1'b0;
      @(negedge clk);
      @(negedge clk); button_in = 1'b1;
      @(negedge clk);
    end
    do_press(20);
    check_level("bounce_press", 1'b1, 8'd2);
    do_release(20);
    check_level("bounce_release", 1'b0, 8'd2);
  endtask

  task automatic test_glitch;
    @(negedge clk); button_in = 1'b0;
    repeat (3) @(negedge clk);
    button_in = 1'b1;
    repeat (20) @(negedge clk);
    check_level("short_glitch", 1'b0, 8'd2);
  endtask

  task automatic test_wrap;
    int p0, r0;
    p0 = n_press;
    r0 = n_release;
    for (int i = 0; i < 256; i++) begin
      do_press(10);
      do_release(10);
    end
    repeat (5) @(negedge clk);
    check_level("wrap_count", 1'b0, 8'd2);
    checks++;
    if (n_press - p0 != 256 || n_release - r0 != 256) begin
      failures++;
      $display("FAIL wrap_pulses actual: press=%0d release=%0d required: 256 256", n_press - p0, n_release - r0);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk); button_in = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pressed !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0 || press_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset actual: p=%0b pp=%0b rp=%0b cnt=%0d required: 0 0 0 0",
               pressed, press_pulse, release_pulse, press_count);
    end
    @(negedge clk);
    rst       = 1'b0;
    exp_count = 8'd1;
    exp_q.push_back('{1'b1, cyc + 7, exp_count});
    repeat (12) @(negedge clk);
    check_level("requalify_after_reset", 1'b1, 8'd1);
    do_release(20);
    check_level("release_after_reset", 1'b0, 8'd1);
  endtask

  initial begin
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_glitch();
    test_wrap();
    test_reset_mid_wait();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
